// File: rtl/cube_root_sched_if.sv
// Request/response channel bundle between the client blocks and cube_root_sched.
// master: client side (drives operands, accepts responses).
// slave : scheduler side.
interface cube_root_sched_if #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic signed [10:0] rsp_rez;
    logic signed [32:0] rsp_r;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_rez, rsp_r
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_rez, rsp_r
    );
endinterface

// File: rtl/cube_root_sched.sv
// Round-robin scheduler sharing a single CubeRoot engine between NREQ requesters.
// An operand is accepted in IDLE, the engine is cleared for one cycle (LOAD),
// iterated for ITER_CYCLES cycles (RUN), and rez/r are returned tagged with the
// requester id (DONE).
// Optional build macro: CUBE_SCHED_FIXED_PRIO_EN -- lowest-index requester always
// wins and the round-robin pointer is held at 0.
module cube_root_sched #(
    parameter int NREQ        = 4,
    parameter int ID_W        = 2,
    parameter int ITER_CYCLES = 12
) (
    input  logic               clk,
    input  logic               rst,
    cube_root_sched_if.slave   bus,
    output logic [31:0]        eng_D,
    output logic               eng_run,
    input  logic signed [10:0] eng_rez,
    input  logic signed [32:0] eng_r,
    output logic               busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] CNT_LAST = 4'(ITER_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [31:0]        d_q, d_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic signed [10:0] rez_q, rez_d;
    logic signed [32:0] r_q, r_d;

    logic [PTR_W-1:0]   grant;
    logic               any_valid;
    logic               hs;
    logic [NREQ-1:0][31:0] req_words;

    assign req_words = bus.req_data;
    assign hs        = (state_q == IDLE) && any_valid;

    // Grant search: first valid requester starting at the pointer, wrapping mod NREQ
    always_comb begin
        logic [PTR_W-1:0] base;
        logic [PTR_W-1:0] idx;
        grant     = '0;
        any_valid = 1'b0;
        idx       = '0;
`ifdef CUBE_SCHED_FIXED_PRIO_EN
        base      = '0;
`else
        base      = ptr_q;
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = PTR_W'((32'(base) + i) % NREQ);
            if (!any_valid && bus.req_valid[idx]) begin
                any_valid = 1'b1;
                grant     = idx;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rez_q       <= '0;
            r_q         <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rez_q       <= rez_d;
            r_q         <= r_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = LOAD;
            LOAD:    state_d = RUN;
            RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates: operand/id capture, iteration counter, result capture
    always_comb begin
        ptr_d       = ptr_q;
        id_d        = id_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rez_d       = rez_q;
        r_d         = r_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    d_d  = req_words[grant];
                    id_d = ID_W'(grant);
`ifndef CUBE_SCHED_FIXED_PRIO_EN
                    ptr_d = (32'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
`endif
                end
            end
            LOAD: cnt_d = '0;
            RUN: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    rez_d       = eng_rez;
                    r_d         = eng_r;
                    rsp_valid_d = 1'b1;
                end
            end
            DONE: if (bus.rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
    end

    // Outputs: grant is offered only in IDLE and never while reset is asserted
    always_comb begin
        bus.req_ready = '0;
        if ((state_q == IDLE) && rst && any_valid) bus.req_ready[grant] = 1'b1;
        eng_run = (state_q == RUN);
        busy    = (state_q != IDLE);
    end

    assign eng_D         = d_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_rez   = rez_q;
    assign bus.rsp_r     = r_q;

endmodule

// File: tb/tb_cube_root_sched.sv
// Testbench for cube_root_sched: behavioural engine, per-cycle reference model,
// directed literal scenarios and a randomized phase.
module tb_cube_root_sched;

    localparam int NREQ = 4;
    localparam int ID_W = 2;
    localparam int ITER = 12;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [31:0]        eng_D;
    logic               eng_run;
    logic signed [10:0] eng_rez;
    logic signed [32:0] eng_r;
    logic               busy;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;

    cube_root_sched_if #(.NREQ(NREQ), .ID_W(ID_W)) bus();

    cube_root_sched #(.NREQ(NREQ), .ID_W(ID_W), .ITER_CYCLES(ITER)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .eng_D   (eng_D),
        .eng_run (eng_run),
        .eng_rez (eng_rez),
        .eng_r   (eng_r),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Truncating integer cube root and its remainder
    function automatic longint cbrt_rez(input longint d);
        longint a, lo, hi, mid;
        a  = (d < 0) ? -d : d;
        lo = 0;
        hi = 2048;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid * mid <= a) lo = mid;
            else hi = mid;
        end
        return (d < 0) ? -lo : lo;
    endfunction

    function automatic longint cbrt_rem(input longint d);
        longint q;
        q = cbrt_rez(d);
        return d - q * q * q;
    endfunction

    function automatic logic [31:0] rand_op();
        longint m;
        m = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 3000))
                                        : longint'($urandom_range(0, 1000000000));
        if ($urandom_range(0, 1) == 1) m = -m;
        return 32'(m);
    endfunction

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Engine model: rez/r become valid only after ITER-1 iterating edges; garbage before
    int run_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) run_cnt <= 0;
        else if (eng_run) run_cnt <= run_cnt + 1;
        else run_cnt <= 0;
    end

    always_comb begin
        longint dv, q, rm;
        dv = longint'($signed(eng_D));
        q  = cbrt_rez(dv);
        rm = dv - q * q * q;
        if (run_cnt >= ITER - 1) begin
            eng_rez = 11'(q);
            eng_r   = 33'(rm);
        end else begin
            eng_rez = ~11'(q);
            eng_r   = ~33'(rm);
        end
    end

    // Reference model: timeline of one job measured from its accept cycle
    bit          m_idle = 1'b1;
    int          m_ptr  = 0;
    int          m_e    = 0;
    int          m_id   = 0;
    logic [31:0] m_data = '0;
    longint      m_rez  = 0;
    longint      m_r    = 0;

    // Per-cycle compare against the model, sampled on the falling edge
    always @(negedge clk) begin
        int g;
        int base;
        logic [NREQ-1:0] exp_rdy;
        if (!rst) begin
            m_idle = 1'b1;
            m_ptr  = 0;
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_eng_run", eng_run, 0);
            chk("rst_busy", busy, 0);
        end else if (m_idle) begin
`ifdef CUBE_SCHED_FIXED_PRIO_EN
            base = 0;
`else
            base = m_ptr;
`endif
            g = -1;
            for (int i = 0; i < NREQ; i++) begin
                int k;
                k = (base + i) % NREQ;
                if (g < 0 && bus.req_valid[k]) g = k;
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("idle_req_ready", bus.req_ready, exp_rdy);
            chk("idle_busy", busy, 0);
            chk("idle_rsp_valid", bus.rsp_valid, 0);
            chk("idle_eng_run", eng_run, 0);
            if (g >= 0) begin
                m_id   = g;
                m_data = bus.req_data[g*32 +: 32];
                m_rez  = cbrt_rez(longint'($signed(m_data)));
                m_r    = cbrt_rem(longint'($signed(m_data)));
                m_e    = 0;
                m_idle = 1'b0;
`ifndef CUBE_SCHED_FIXED_PRIO_EN
                m_ptr  = (g + 1) % NREQ;
`endif
            end
        end else begin
            m_e++;
            chk("job_req_ready", bus.req_ready, 0);
            chk("job_busy", busy, 1);
            chk("job_eng_D", eng_D, m_data);
            chk("job_eng_run", eng_run, (m_e >= 2 && m_e <= ITER + 1));
            chk("job_rsp_valid", bus.rsp_valid, (m_e >= ITER + 2));
            if (m_e >= ITER + 2) begin
                chk("rsp_id", bus.rsp_id, m_id);
                chk("rsp_rez", bus.rsp_rez, m_rez);
                chk("rsp_r", bus.rsp_r, m_r);
                if (bus.rsp_ready) m_idle = 1'b1;
            end
        end
    end

    task automatic wait_hs(output int k, output int t);
        k = -1;
        t = 0;
        for (int n = 0; n < 64 && k < 0; n++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++)
                if (k < 0 && bus.req_valid[i] && bus.req_ready[i]) begin
                    k = i;
                    t = cyc;
                end
        end
        if (k < 0) begin
            vectors++;
            errs++;
            $display("FAIL hs_timeout: got no handshake required one within 64 cycles");
        end
    endtask

    task automatic wait_rsp(output int t);
        bit seen;
        seen = 1'b0;
        t    = 0;
        for (int n = 0; n < 64 && !seen; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1'b1;
                t    = cyc;
            end
        end
        if (!seen) begin
            vectors++;
            errs++;
            $display("FAIL rsp_timeout: got no rsp_valid required one within 64 cycles");
        end
    endtask

    task automatic job(input int k, input logic [31:0] d, input longint er, input longint err_);
        int g, t, t2;
        @(posedge clk); #1;
        bus.req_valid          = '0;
        bus.req_valid[k]       = 1'b1;
        bus.req_data[k*32 +: 32] = d;
        bus.rsp_ready          = 1'b1;
        wait_hs(g, t);
        chk("dir_grant", g, k);
        @(posedge clk); #1;
        bus.req_valid[k] = 1'b0;
        wait_rsp(t2);
        chk("dir_latency", t2 - t, ITER + 2);
        chk("dir_id", bus.rsp_id, k);
        chk("dir_rez", bus.rsp_rez, er);
        chk("dir_r", bus.rsp_r, err_);
        @(posedge clk); #1;
    endtask

    initial begin
        int g, t, t2;
        logic [31:0] d_tab [4];
        longint rez_tab [4];

        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_eng_D", eng_D, 0);
        chk("reset_rsp_id", bus.rsp_id, 0);
        chk("reset_rsp_rez", bus.rsp_rez, 0);
        chk("reset_rsp_r", bus.rsp_r, 0);
        chk("reset_req_ready_valid_high", bus.req_ready, 0);
        bus.req_valid = '0;
        rst = 1'b1;
        @(posedge clk); #1;

        // Model pinning against hand-computed roots
        chk("model_75366", cbrt_rez(75366), 42);
        chk("model_-27000000_r", cbrt_rem(-27000000), 0);

`ifndef CUBE_SCHED_FIXED_PRIO_EN
        // All four requesters pending: grants rotate 0,1,2,3
        d_tab   = '{32'(-27000000), 32'(-1), 32'd1000, 32'd8};
        rez_tab = '{-300, -1, 10, 2};
        for (int k = 0; k < NREQ; k++) bus.req_data[k*32 +: 32] = d_tab[k];
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int j = 0; j < NREQ; j++) begin
            wait_hs(g, t);
            chk("rr_grant", g, j);
            @(posedge clk); #1;
            if (g >= 0) bus.req_valid[g] = 1'b0;
            wait_rsp(t2);
            chk("rr_id", bus.rsp_id, j);
            chk("rr_rez", bus.rsp_rez, rez_tab[j]);
            chk("rr_r", bus.rsp_r, 0);
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
`else
        // Requesters 0 and 3 both pending: 0 wins every job
        bus.req_data[0 +: 32]  = 32'd8;
        bus.req_data[96 +: 32] = 32'd1000;
        bus.req_valid = 4'b1001;
        bus.rsp_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            wait_hs(g, t);
            chk("fp_grant", g, 0);
            wait_rsp(t2);
            chk("fp_rez", bus.rsp_rez, 2);
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (20) @(posedge clk);
        #1;
`endif

        job(0, 32'(-1000000), -100, 0);
        job(2, 32'd75366, 42, 1278);
        job(2, 32'd1730482, 120, 2482);
        job(2, 32'd421, 7, 78);

        // Backpressure: response held 20 cycles while another requester waits
        @(posedge clk); #1;
        bus.req_valid          = 4'b0010;
        bus.req_data[32 +: 32] = 32'd421;
        bus.rsp_ready          = 1'b0;
        wait_hs(g, t);
        chk("bp_grant", g, 1);
        @(posedge clk); #1;
        bus.req_valid          = 4'b1000;
        bus.req_data[96 +: 32] = 32'd8;
        wait_rsp(t2);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_id", bus.rsp_id, 1);
            chk("bp_rez", bus.rsp_rez, 7);
            chk("bp_r", bus.rsp_r, 78);
            chk("bp_req_ready", bus.req_ready, 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", bus.rsp_valid, 1);
        @(negedge clk);
        chk("bp_idle_busy", busy, 0);
        chk("bp_next_grant", bus.req_ready, 4'b1000);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_rsp(t2);
        chk("bp_next_rez", bus.rsp_rez, 2);
        @(posedge clk); #1;

        // Reset abort at RUN count 5
        bus.req_valid         = 4'b0001;
        bus.req_data[0 +: 32] = 32'd1000;
        wait_hs(g, t);
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_pre_run", eng_run, 1);
        chk("abort_pre_busy", busy, 1);
        bus.req_valid = '1;
        rst = 1'b0;
        #1;
        chk("abort_eng_run", eng_run, 0);
        chk("abort_eng_D", eng_D, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_rsp_id", bus.rsp_id, 0);
        chk("abort_rsp_rez", bus.rsp_rez, 0);
        chk("abort_rsp_r", bus.rsp_r, 0);
        chk("abort_req_ready", bus.req_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            chk("abort_no_stale", bus.rsp_valid, 0);
        end

        // Randomized traffic, checked cycle by cycle against the model
        for (int n = 0; n < 2500; n++) begin
            @(posedge clk); #1;
            bus.rsp_ready = ($urandom_range(0, 9) < 6);
            for (int k = 0; k < NREQ; k++) begin
                bus.req_valid[k]         = ($urandom_range(0, 3) == 0);
                bus.req_data[k*32 +: 32] = rand_op();
            end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
